// File: rtl/impl_window_checker_if.sv
// impl_window_checker_if: stimulus and result bundle of the window checker (vac_cnt only with IMPL_CHK_VACUOUS_EN)
interface impl_window_checker_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 16
);
    logic                 en;
    logic                 clr;
    logic [NCH-1:0]       ante;
    logic [NCH-1:0]       cons;
    logic [NCH-1:0]       pass_pulse;
    logic [NCH-1:0]       fail_pulse;
    logic [NCH-1:0]       err_sticky;
    logic [NCH*CNT_W-1:0] pass_cnt;
    logic [NCH*CNT_W-1:0] fail_cnt;
`ifdef IMPL_CHK_VACUOUS_EN
    logic [NCH*CNT_W-1:0] vac_cnt;
`endif
    modport master (
        output en, clr, ante, cons,
`ifdef IMPL_CHK_VACUOUS_EN
        input  vac_cnt,
`endif
        input  pass_pulse, fail_pulse, err_sticky, pass_cnt, fail_cnt
    );
    modport slave (
        input  en, clr, ante, cons,
`ifdef IMPL_CHK_VACUOUS_EN
        output vac_cnt,
`endif
        output pass_pulse, fail_pulse, err_sticky, pass_cnt, fail_cnt
    );
endinterface

// File: rtl/impl_window_checker.sv
// impl_window_checker: per-channel ante |-> ##[MIN_DLY:MAX_DLY] cons checker; IMPL_CHK_VACUOUS_EN adds vac_cnt
module impl_window_checker #(
    parameter int NCH     = 4,
    parameter int MIN_DLY = 0,
    parameter int MAX_DLY = 3,
    parameter int CNT_W   = 16
) (
    input logic                  clk,
    input logic                  rst,
    impl_window_checker_if.slave bus
);
    localparam int AW = MAX_DLY + 1;
    localparam int SW = CNT_W + 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [AW-1:0] WIN = {AW{1'b1}} << MIN_DLY;

    if (MIN_DLY < 0 || MAX_DLY < MIN_DLY || MAX_DLY > 15) begin : g_bad_dly
        $error("impl_window_checker: requires 0 <= MIN_DLY <= MAX_DLY <= 15");
    end

    logic [AW-1:0]                 pend_q [NCH];
    logic [AW-1:0]                 pend_d [NCH];
    logic [AW-1:0]                 alive  [NCH];
    logic [AW-1:0]                 hit    [NCH];
    logic [4:0]                    npass  [NCH];
    logic [NCH-1:0]                pass_v, fail_v;
    logic [NCH-1:0]                pass_pulse_q, fail_pulse_q, err_q, err_d;
    logic [NCH-1:0][CNT_W-1:0]     pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [4:0] b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        return (s > SW'(CNT_MAX)) ? CNT_MAX : s[CNT_W-1:0];
    endfunction

    // Evaluate every alive attempt (including this edge's new one): in-window cons passes, age MAX_DLY without cons fails, the rest age by one
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            alive[i]      = pend_q[i] | AW'(bus.en & bus.ante[i]);
            hit[i]        = alive[i] & WIN & {AW{bus.cons[i]}};
            npass[i]      = 5'($countones(hit[i]));
            pass_v[i]     = |hit[i];
            fail_v[i]     = alive[i][MAX_DLY] & ~bus.cons[i];
            pend_d[i]     = AW'({alive[i] & ~hit[i], 1'b0});
            pass_cnt_d[i] = bus.clr ? '0 : sat_add(pass_cnt_q[i], npass[i]);
            fail_cnt_d[i] = bus.clr ? '0 : sat_add(fail_cnt_q[i], 5'(fail_v[i]));
            err_d[i]      = ~bus.clr & (err_q[i] | fail_v[i]);
        end
    end

    // Register attempt state and all results; reset drops in-flight attempts without reporting them
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q       <= '{default: '0};
            pass_pulse_q <= '0;
            fail_pulse_q <= '0;
            err_q        <= '0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
        end else begin
            pend_q       <= pend_d;
            pass_pulse_q <= pass_v;
            fail_pulse_q <= fail_v;
            err_q        <= err_d;
            pass_cnt_q   <= pass_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
        end
    end

    assign bus.pass_pulse = pass_pulse_q;
    assign bus.fail_pulse = fail_pulse_q;
    assign bus.err_sticky = err_q;
    assign bus.pass_cnt   = pass_cnt_q;
    assign bus.fail_cnt   = fail_cnt_q;

`ifdef IMPL_CHK_VACUOUS_EN
    logic [NCH-1:0][CNT_W-1:0] vac_cnt_q, vac_cnt_d;

    // Count enabled edges where the antecedent is absent
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            vac_cnt_d[i] = bus.clr ? '0 : sat_add(vac_cnt_q[i], 5'(bus.en & ~bus.ante[i]));
        end
    end

    // Vacuous counter register
    always_ff @(posedge clk) begin
        if (rst) vac_cnt_q <= '0;
        else     vac_cnt_q <= vac_cnt_d;
    end

    assign bus.vac_cnt = vac_cnt_q;
`endif
endmodule

// File: doc/impl_window_checker.md
# impl_window_checker

Synthesizable, parametrised multi-channel implication checker: for each channel, an antecedent pulse opens an attempt that passes if the consequent is seen within a delay window `[MIN_DLY, MAX_DLY]` cycles, and fails otherwise. It is the hardware counterpart of `ante |-> ##[MIN_DLY:MAX_DLY] cons` with per-attempt threads, pass/fail pulses and saturating counters. It sits beside the design under check and is readable by the bench or by the debug register bank.

## Interface
Parameters:
- `NCH`, 4, number of independent channels.
- `MIN_DLY`, 0, earliest accepted consequent age in cycles (0 = same-cycle, overlapping implication).
- `MAX_DLY`, 3, latest accepted consequent age; legal range `MIN_DLY <= MAX_DLY <= 15`, else `$error` at elaboration.
- `CNT_W`, 16, width of each per-channel counter.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  enables new attempts.
- `ante`  in  NCH  per-channel antecedent.
- `cons`  in  NCH  per-channel consequent.
- `clr`  in  1  clears counters and sticky flags.
- `pass_pulse`  out  NCH  at least one attempt passed this edge.
- `fail_pulse`  out  NCH  at least one attempt failed this edge.
- `err_sticky`  out  NCH  set on any fail, held until `clr`/`rst`.
- `pass_cnt`  out  NCH*CNT_W  packed per-channel pass counts; channel i in bits `[i*CNT_W +: CNT_W]`.
- `fail_cnt`  out  NCH*CNT_W  packed per-channel fail counts.

## Operation
- Each channel holds a pending vector `pend[0..MAX_DLY]`. Bit k means an attempt of age k is alive.
- New attempt: `en && ante[i]` sampled at an edge creates an attempt of age 0 that is evaluated on that same edge.
- Evaluation of each alive attempt of age k, with `cons[i]` sampled at the same edge:
  - `MIN_DLY <= k` and `cons` high: pass, and the attempt retires (first match).
  - `k == MAX_DLY` and no pass: fail, and the attempt retires.
  - Otherwise the attempt ages to k+1.
- Attempts are independent threads. One `cons` cycle passes every alive attempt inside its window.
- Counters add the number of attempts resolved per edge, not 1, and saturate at all-ones.
- `en` low blocks only new attempts; in-flight attempts still resolve.
- `clr` zeroes counters and `err_sticky`. It does not touch `pend`.
  - `clr` has priority over a same-edge increment: the result is 0 and the increment is lost.
  - `clr` has priority over a same-edge sticky set.
- Reset (`rst` high at an edge) clears `pend`, both pulses, counters and `err_sticky` to 0. All outputs read 0 after the reset edge. In-flight attempts are discarded silently, with no fail reported.

## Timing
- All outputs are registered.
- An attempt resolved at edge t shows its result in the cycle after edge t: pulse high for exactly one cycle, counter updated, sticky set.
- With `MIN_DLY=0`, `ante` and `cons` high at edge t pass with zero added latency (pulse after edge t).
- Fail for an antecedent at edge t with no consequent is reported at edge t+MAX_DLY.
- Pass and fail on the same channel at the same edge (different attempts): both pulses high and both counters increment.

## Configuration
- `IMPL_CHK_VACUOUS_EN`
- Defined:
  - Adds output `vac_cnt` (NCH*CNT_W) counting edges with `en` high and `ante[i]` low, i.e. vacuous passes.
  - Saturating, cleared by `clr`/`rst` with the same rules as the other counters.
- Undefined: the port and its logic are absent.

## Test plan
All scenarios use NCH=2, MIN_DLY=1, MAX_DLY=3, CNT_W=16 unless noted.
- `ante[0]` at edge 5, `cons[0]` at edge 7 -> `pass_pulse[0]` high one cycle after edge 7; `pass_cnt` ch0=1; `fail_cnt` ch0=0.
- `ante[0]` at edge 5, `cons[0]` low throughout -> `fail_pulse[0]` after edge 8; `fail_cnt` ch0=1; `err_sticky[0]`=1 until `clr` at edge 12, then 0.
- `ante[1]` and `cons[1]` only at edge 5 (age 0 < MIN_DLY) -> no pass; fail after edge 8. Same stimulus with MIN_DLY=0 -> pass after edge 5.
- `ante[0]` at edges 5 and 6, `cons[0]` at edge 7 -> single `pass_pulse` after edge 7; `pass_cnt` ch0=2.
- CNT_W=2, five separate passing attempts on ch0 -> `pass_cnt` ch0 stays 3; a `clr` coinciding with a pass -> count 0.
- `ante[0]` at edge 5, `rst` at edge 6, `cons[0]` at edge 7 -> no pulses, all counters 0, `err_sticky`=0.
